// File: rtl/estimador_operand_arbiter.sv
// estimador_operand_arbiter: round-robin arbiter with burst lock driving the shared 3:1 operand mux.
module estimador_operand_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    output logic [1:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] mux_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);
    typedef enum logic {IDLE, LOCKED} state_e;
    localparam logic [3:0] MAX = 4'(MAX_BURST);
    state_e                state_q, state_d;
    logic [1:0]            owner_q, owner_d, mux_sel_q, grant, nxt1, nxt2;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]            out_src_q, out_src_d;
    logic                  out_valid_q, out_valid_d;
    logic                  slot, others, keep, has_grant, acc;
    always_comb begin
        slot      = !out_valid_q || out_ready;
        others    = |(req_valid & ~(3'b001 << owner_q));
        keep      = state_q == LOCKED && req_valid[owner_q] && (cnt_q < MAX || !others);
        nxt1      = owner_q == 2'd2 ? 2'd0 : owner_q + 2'd1;
        nxt2      = owner_q == 2'd0 ? 2'd2 : owner_q - 2'd1;
        has_grant = keep || |req_valid;
        grant     = keep ? owner_q : req_valid[nxt1] ? nxt1 : req_valid[nxt2] ? nxt2 : owner_q;
        acc       = ap_rst_n && slot && has_grant;
        req_ready = acc ? 3'b001 << grant : 3'b000;
        mux_sel   = !ap_rst_n ? 2'd0 : has_grant ? grant : mux_sel_q;
    end
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (acc) begin
            out_data_d  = mux_dout;
            out_src_d   = grant;
            out_valid_d = 1'b1;
            if (state_q == LOCKED && grant == owner_q) begin
                cnt_d = cnt_q == MAX ? cnt_q : cnt_q + 4'd1;
            end else begin
                owner_d = grant;
                state_d = LOCKED;
                cnt_d   = 4'd1;
            end
        end else begin
            out_valid_d = out_ready ? 1'b0 : out_valid_q;
            // owner stays put on release so it keeps acting as the round-robin pointer
            if (slot && !req_valid[owner_q] && state_q == LOCKED) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'd2;
            cnt_q       <= 4'd0;
            mux_sel_q   <= 2'd0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mux_sel_q   <= mux_sel;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_estimador_operand_arbiter.sv
// tb_estimador_operand_arbiter: directed scoreboard bench for the operand arbiter.
module tb_estimador_operand_arbiter;
    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } beat_t;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic        out_ready = 1'b0;
    logic [2:0]  req_ready;
    logic [1:0]  mux_sel, out_src;
    logic [31:0] mux_dout, out_data;
    logic        out_valid;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;
    logic        seq_clr = 1'b0;
    int          seq[3];
    int          exp_cnt[3];
    beat_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    int          g1[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};

    estimador_operand_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mux_sel(mux_sel), .mux_dout(mux_dout), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [31:0] data_of(input logic [1:0] s, input int n);
        return {6'd1, s, 24'(n)};
    endfunction

    assign mux_dout = ovr_en ? ovr_val : (mux_sel == 2'd3) ? 32'hDEAD_BEEF : data_of(mux_sel, seq[mux_sel]);

    // each source advances its operand only when its beat is actually taken
    always @(posedge ap_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (seq_clr) seq[i] <= 0;
            else if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s);
        sb.push_back({s, data_of(s, exp_cnt[s])});
        exp_cnt[s]++;
    endtask

    task automatic push_val(input logic [1:0] s, input logic [31:0] d);
        sb.push_back({s, d});
    endtask

    task automatic sb_check();
        beat_t e;
        if (out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_underflow: observed unexpected beat src %0d data %h expected none", out_src, out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_src", 32'(out_src), 32'(e.src));
                check("out_data", out_data, e.data);
            end
        end
    endtask

    task automatic step(input logic [2:0] exp_rdy);
        @(negedge ap_clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        sb_check();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clr();
        seq_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        seq_clr = 1'b0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    endtask

    task automatic drain();
        req_valid = 3'b000;
        step(3'b000);
        check("drained", 32'(sb.size()), 32'd0);
        clr();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_src"}, 32'(out_src), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        req_valid = 3'b111;
        #12;
        reset_checks("rst");
        req_valid = 3'b000;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        // all three requesting: runs of four beats per owner, no bubbles
        req_valid = 3'b111;
        for (int k = 0; k < 13; k++) begin
            push(2'(g1[k]));
            step(3'b001 << g1[k]);
        end
        drain();
        // lone requester keeps the grant past the burst limit
        req_valid = 3'b010;
        for (int k = 0; k < 10; k++) begin
            push(2'd1);
            step(3'b010);
        end
        drain();
        // back-pressure on a src2 stream
        req_valid = 3'b100;
        push(2'd2);
        step(3'b100);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(3'b000);
            check("stall_data", out_data, data_of(2'd2, 0));
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        push(2'd2);
        step(3'b100);
        push(2'd2);
        step(3'b100);
        drain();
        // early release of src0 hands over to src1 with a fresh burst count
        req_valid = 3'b001;
        push(2'd0);
        step(3'b001);
        push(2'd0);
        step(3'b001);
        req_valid = 3'b110;
        for (int k = 0; k < 4; k++) begin
            push(2'd1);
            step(3'b010);
        end
        push(2'd2);
        step(3'b100);
        drain();
        // reload while the previous beat is being consumed
        ovr_en = 1'b1;
        ovr_val = 32'hA5A5_0000;
        req_valid = 3'b001;
        push_val(2'd0, 32'hA5A5_0000);
        step(3'b001);
        ovr_val = 32'h5A5A_FFFF;
        push_val(2'd0, 32'h5A5A_FFFF);
        step(3'b001);
        check("simul_valid", 32'(out_valid), 32'd1);
        check("simul_data", out_data, 32'h5A5A_FFFF);
        drain();
        ovr_en = 1'b0;
        // asynchronous reset in the middle of a src1 burst
        req_valid = 3'b010;
        push(2'd1);
        step(3'b010);
        push(2'd1);
        step(3'b010);
        #2;
        ap_rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        sb.delete();
        req_valid = 3'b000;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        clr();
        req_valid = 3'b111;
        push(2'd0);
        step(3'b001);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/estimador_operand_arbiter.md
# estimador_operand_arbiter

Round-robin arbiter that shares the estimator's 32-bit 3:1 operand mux between three requesting producers. It drives the mux select, captures the mux output into a one-entry output register, and presents it to the downstream arithmetic unit over a valid/ready handshake. A burst counter lets the current owner keep the path for up to MAX_BURST consecutive beats before the grant rotates.

## Interface
- DATA_WIDTH, 32, operand width; matches the mux data width.
- MAX_BURST, 4, maximum consecutive beats per owner while another requester is waiting; legal range 1..15.
- ap_clk  in  1  single clock; all state updates on its rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  3  bit i set: requester i holds a valid operand.
- req_ready  out  3  bit i set: requester i's operand is taken this cycle; at most one bit is high.
- mux_sel  out  2  select for the shared mux: 2'b00 = src0, 2'b01 = src1, 2'b10 = src2.
- mux_dout  in  DATA_WIDTH  shared mux output, combinational from mux_sel.
- out_data  out  DATA_WIDTH  registered operand.
- out_src  out  2  index of the requester that supplied out_data.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  downstream accepts.

## Operation
- Transfer slot: `slot = !out_valid || out_ready`.
- Grant is combinational from current state and req_valid.
  - Locked with `req_valid[owner]` and `cnt < MAX_BURST`: grant = owner.
  - Locked, `cnt == MAX_BURST`, and no other requester valid: grant = owner, and cnt stays at MAX_BURST.
  - Otherwise: grant goes to the first valid requester scanning (owner+1, owner+2, owner) mod 3.
  - No requester valid: no grant.
- `req_ready[i] = slot && grant==i`. A beat is accepted when req_ready and req_valid are both high for the same requester.
- mux_sel is the granted index. With no grant, mux_sel holds its last value; its reset value is 2'b00.
- On acceptance:
  - out_data <= mux_dout, out_src <= grant, out_valid <= 1.
  - If grant == owner and locked: cnt <= sat(cnt+1).
  - Else: owner <= grant, locked <= 1, cnt <= 1.
- When there is no acceptance and out_ready is high, out_valid <= 0.
- Lock release: if a slot exists, `req_valid[owner]` is low and locked is set, then locked <= 0 and cnt <= 0. Owner is retained as the round-robin pointer.
- State machine, encoded by the locked bit:
  - IDLE (locked=0) → LOCKED on any acceptance.
  - LOCKED → LOCKED with a new owner on rotation.
  - LOCKED → IDLE on release.
- Reset values: owner = 2 (so src0 wins first), locked = 0, cnt = 0, out_valid = 0, out_data = 0, out_src = 0, req_ready = 0, mux_sel = 0.
- Reset asserted mid-burst discards any held out_data immediately. No beat is accepted while ap_rst_n is low.

## Timing
- Latency: operand accepted in cycle N appears on out_data with out_valid high in cycle N+1.
- Throughput: one beat per cycle while out_ready is held high.
- Back-pressure: while out_valid is high and out_ready is low, out_data, out_src and out_valid hold, and all req_ready bits are 0.
- If a requester drops valid while stalled, its beat is not counted.
- Simultaneous out_ready and acceptance: the register reloads with the new beat and out_valid stays high.
- Requester rules: req_valid must not depend on req_ready. Data must be stable on the mux while valid is high.
- Rotation takes effect in the cycle after the MAX_BURST-th beat is accepted. There is no bubble between owners.
- cnt is 4 bits wide and saturates at MAX_BURST.

## Test plan
- Reset, then req_valid=3'b111 with out_ready=1 held:
  - Grants 0,0,0,0,1,1,1,1,2,2,2,2,0…, each run being MAX_BURST=4 beats.
  - out_src follows the same sequence, one cycle later.
  - No idle cycles.
- Single requester: only req_valid[1] high for 10 cycles:
  - 10 consecutive beats, all with out_src=1.
  - cnt saturates at 4 and the grant never drops.
- Back-pressure: src2 streaming, out_ready=0 for 3 cycles:
  - out_data holds the first beat.
  - req_ready=0 during the stall.
  - Transfers resume the cycle out_ready returns high, with no beat lost or duplicated.
- Early release: src0 sends 2 beats, then drops valid while src1 and src2 are valid:
  - The next grant goes to src1.
  - locked restarts with cnt=1.
- Simultaneous events: out_ready=1 and a new acceptance in the same cycle:
  - out_valid stays high and out_data updates to the new mux_dout.
  - Checked with distinct values 0xA5A5_0000 followed by 0x5A5A_FFFF.
- Reset mid-burst: drop ap_rst_n asynchronously after beat 2 of a src1 burst:
  - All outputs go to their reset values immediately.
  - After release, the first grant goes to src0.
